// File: rtl/pong_motion_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_motion_if : command inputs and position/miss outputs of the motion engine
// Rev 1.0
// ---------------------------------------------------------------------------
interface pong_motion_if;
   logic       stop;
   logic       up1;
   logic       down1;
   logic       up2;
   logic       down2;
   logic [3:0] sec1;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [9:0] paddle1_y;
   logic [9:0] paddle2_y;
   logic       miss1;
   logic       miss2;

   modport master (
      output stop, up1, down1, up2, down2, sec1,
      input  ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2
   );

   modport slave (
      input  stop, up1, down1, up2, down2, sec1,
      output ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2
   );
endinterface
`default_nettype wire

// File: rtl/pong_motion_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_motion_engine : ball and paddle physics advanced on a divided move tick
// Rev 1.0
// ---------------------------------------------------------------------------
module pong_motion_engine #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_H    = 64,
   parameter int PADDLE1_X   = 16,
   parameter int PADDLE2_X   = 616,
   parameter int PADDLE_STEP = 4,
   parameter int TICK_DIV    = 250000,
   parameter int MAX_SPEED   = 4
) (
   input  logic         clk,
   input  logic         rst,
   pong_motion_if.slave bus
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam int SPD_W = $clog2(MAX_SPEED + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_SPEED);
   localparam logic [SPD_W-1:0] SPD_INIT = SPD_W'(1);

   localparam logic [10:0] FIELD_W    = 11'(SCREEN_W);
   localparam logic [10:0] FIELD_H    = 11'(SCREEN_H);
   localparam logic [10:0] BALL       = 11'(BALL_SIZE);
   localparam logic [10:0] PAD_H      = 11'(PADDLE_H);
   localparam logic [10:0] STEP       = 11'(PADDLE_STEP);
   localparam logic [10:0] LEFT_FACE  = 11'(PADDLE1_X + PADDLE_W);
   localparam logic [10:0] RIGHT_FACE = 11'(PADDLE2_X);
   localparam logic [10:0] PAD_Y_MAX  = 11'(SCREEN_H - PADDLE_H);

   localparam logic [9:0] X_MAX      = 10'(SCREEN_W - BALL_SIZE);
   localparam logic [9:0] Y_MAX      = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0] X_CENTRE   = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0] Y_CENTRE   = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [9:0] PAD_INIT   = 10'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [9:0] LEFT_STOP  = 10'(PADDLE1_X + PADDLE_W);
   localparam logic [9:0] RIGHT_STOP = 10'(PADDLE2_X - BALL_SIZE);

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      PLAY  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] tick_cnt;
   logic [SPD_W-1:0] speed;
   logic [3:0]       sec1_q;
   logic [9:0]       ball_x;
   logic [9:0]       ball_y;
   logic [9:0]       paddle1_y;
   logic [9:0]       paddle2_y;
   logic             dx;
   logic             dy;
   logic             miss1;
   logic             miss2;

   logic        tick;
   logic        speed_up;
   logic [10:0] bx;
   logic [10:0] by;
   logic [10:0] p1;
   logic [10:0] p2;
   logic [10:0] spd;
   logic        overlap1;
   logic        overlap2;
   logic        hit_left;
   logic        hit_right;
   logic        miss_left;
   logic        miss_right;
   logic [9:0]  ball_x_nxt;
   logic [9:0]  ball_y_nxt;
   logic        dx_nxt;
   logic        dy_nxt;

   function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up, input logic down);
      logic [10:0] yw;
      yw          = {1'b0, y};
      paddle_move = y;
      if (up && !down)
         paddle_move = (yw < STEP) ? 10'd0 : 10'(yw - STEP);
      else if (down && !up)
         paddle_move = (yw + STEP > PAD_Y_MAX) ? 10'(PAD_Y_MAX) : 10'(yw + STEP);
   endfunction

   assign tick     = (state == PLAY) && !bus.stop && (tick_cnt == CNT_LAST);
   assign speed_up = (state == PLAY) && !bus.stop && (bus.sec1 != sec1_q) && (speed != SPD_MAX);

   // Widened copies keep every sum and compare free of 10-bit wrap.
   assign bx  = {1'b0, ball_x};
   assign by  = {1'b0, ball_y};
   assign p1  = {1'b0, paddle1_y};
   assign p2  = {1'b0, paddle2_y};
   assign spd = 11'(speed);

   assign overlap1   = (by + BALL > p1) && (by < p1 + PAD_H);
   assign overlap2   = (by + BALL > p2) && (by < p2 + PAD_H);
   assign hit_left   = !dx && (bx >= LEFT_FACE) && (bx < LEFT_FACE + spd) && overlap1;
   assign hit_right  = dx && (bx + BALL <= RIGHT_FACE) && (bx + BALL + spd > RIGHT_FACE) && overlap2;
   assign miss_left  = !dx && !hit_left && (bx < spd);
   assign miss_right = dx && !hit_right && (bx + BALL + spd > FIELD_W);

   always_comb begin
      ball_x_nxt = ball_x;
      ball_y_nxt = ball_y;
      dx_nxt     = dx;
      dy_nxt     = dy;

      if (hit_left) begin
         ball_x_nxt = LEFT_STOP;
         dx_nxt     = 1'b1;
      end else if (hit_right) begin
         ball_x_nxt = RIGHT_STOP;
         dx_nxt     = 1'b0;
      end else if (miss_left) begin
         ball_x_nxt = 10'd0;
      end else if (miss_right) begin
         ball_x_nxt = X_MAX;
      end else if (dx) begin
         ball_x_nxt = 10'(bx + spd);
      end else begin
         ball_x_nxt = 10'(bx - spd);
      end

      if (!dy && (by < spd)) begin
         ball_y_nxt = 10'd0;
         dy_nxt     = 1'b1;
      end else if (dy && (by + BALL + spd > FIELD_H)) begin
         ball_y_nxt = Y_MAX;
         dy_nxt     = 1'b0;
      end else if (dy) begin
         ball_y_nxt = 10'(by + spd);
      end else begin
         ball_y_nxt = 10'(by - spd);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SERVE:   if (!bus.stop) state_nxt = PLAY;
         PLAY:    if (tick && (miss_left || miss_right)) state_nxt = HOLD;
         HOLD:    if (bus.stop) state_nxt = SERVE;
         default: state_nxt = SERVE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= SERVE;
         tick_cnt  <= '0;
         speed     <= SPD_INIT;
         sec1_q    <= 4'd0;
         ball_x    <= X_CENTRE;
         ball_y    <= Y_CENTRE;
         paddle1_y <= PAD_INIT;
         paddle2_y <= PAD_INIT;
         dx        <= 1'b1;
         dy        <= 1'b1;
         miss1     <= 1'b0;
         miss2     <= 1'b0;
      end else begin
         state  <= state_nxt;
         sec1_q <= bus.sec1;
         miss1  <= 1'b0;
         miss2  <= 1'b0;

         if (state != PLAY)
            tick_cnt <= '0;
         else if (!bus.stop)
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

         if (speed_up)
            speed <= speed + 1'b1;

         // dx is left untouched on a miss, so the serve heads toward the loser.
         if (state == HOLD && bus.stop) begin
            ball_x <= X_CENTRE;
            ball_y <= Y_CENTRE;
         end else if (tick) begin
            ball_x    <= ball_x_nxt;
            ball_y    <= ball_y_nxt;
            dx        <= dx_nxt;
            dy        <= dy_nxt;
            paddle1_y <= paddle_move(paddle1_y, bus.up1, bus.down1);
            paddle2_y <= paddle_move(paddle2_y, bus.up2, bus.down2);
            miss1     <= miss_left;
            miss2     <= miss_right;
         end
      end
   end

   assign bus.ball_x    = ball_x;
   assign bus.ball_y    = ball_y;
   assign bus.paddle1_y = paddle1_y;
   assign bus.paddle2_y = paddle2_y;
   assign bus.miss1     = miss1;
   assign bus.miss2     = miss2;

endmodule
`default_nettype wire
